// File: rtl/i2c_master_burst_if.sv
// Command/data handshake between the local host and the burst I2C master.
// The master modport is the view of the I2C master itself; slave is the host side.
interface i2c_master_burst_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic [6:0]       addr;
    logic             r_w_en;
    logic [CNT_W-1:0] num_bytes;
    logic [7:0]       tx_data;
    logic             tx_load;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             done;
    logic             ack_err;

    modport master (
        input  start, addr, r_w_en, num_bytes, tx_data,
        output tx_load, rx_data, rx_valid, busy, done, ack_err
    );

    modport slave (
        output start, addr, r_w_en, num_bytes, tx_data,
        input  tx_load, rx_data, rx_valid, busy, done, ack_err
    );
endinterface

// File: rtl/i2c_master_burst.sv
// I2C master running write/read bursts and address-only pings with an open-drain SDA.
// Each bit is four quarters of CLK_DIV clocks: SCL low in Q0-Q1, high in Q2-Q3.
module i2c_master_burst #(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_master_burst_if.master    cmd,
    output logic                  SCL,
    inout  wire                   SDA,
    output logic [3:0]            state_reg
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        START     = 4'd1,
        ADDR      = 4'd2,
        ADDR_ACK  = 4'd3,
        WRITE     = 4'd4,
        WRITE_ACK = 4'd5,
        READ      = 4'd6,
        READ_ACK  = 4'd7,
        STOP      = 4'd8
    } state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    div_cnt;
    logic [1:0]       q;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [CNT_W-1:0] byte_cnt;
    logic             rw;
    logic             ack_smp;
    logic             ack_err;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             tick, bit_end, smp_pt, rx_upd;
    logic             tx_load, done, sda_low, scl;
    logic             sda_in;

    assign sda_in  = SDA;
    assign tick    = (div_cnt == DW'(CLK_DIV - 1));
    assign bit_end = tick && (q == 2'd3);
    assign smp_pt  = tick && (q == 2'd2);
    assign rx_upd  = (state == READ) && (q == 2'd3) && (div_cnt == '0) && (bit_cnt == 3'd7);

    always_comb begin
        state_nxt = state;
        tx_load   = 1'b0;
        done      = 1'b0;
        sda_low   = 1'b0;
        scl       = q[1];
        case (state)
            IDLE: begin
                scl = 1'b1;
                if (cmd.start) state_nxt = START;
            end
            START: begin
                scl     = 1'b1;
                sda_low = q[1];
                if (bit_end) state_nxt = ADDR;
            end
            ADDR: begin
                sda_low = !shreg[7];
                if (bit_end && bit_cnt == 3'd7) state_nxt = ADDR_ACK;
            end
            ADDR_ACK: begin
                if (bit_end) begin
                    if (ack_smp || byte_cnt == '0) state_nxt = STOP;
                    else if (rw)                   state_nxt = READ;
                    else                           state_nxt = WRITE;
                end
            end
            WRITE: begin
                tx_load = (bit_cnt == 3'd0) && (q == 2'd0) && (div_cnt == '0);
                // The first bit is driven straight from tx_data while it is being latched.
                sda_low = tx_load ? !cmd.tx_data[7] : !shreg[7];
                if (bit_end && bit_cnt == 3'd7) state_nxt = WRITE_ACK;
            end
            WRITE_ACK: begin
                if (bit_end) begin
                    if (ack_smp || byte_cnt == CNT_W'(1)) state_nxt = STOP;
                    else                                  state_nxt = WRITE;
                end
            end
            READ: begin
                if (bit_end && bit_cnt == 3'd7) state_nxt = READ_ACK;
            end
            READ_ACK: begin
                sda_low = (byte_cnt != CNT_W'(1));
                if (bit_end) state_nxt = (byte_cnt == CNT_W'(1)) ? STOP : READ;
            end
            STOP: begin
                sda_low = (q != 2'd3);
                if (bit_end) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            q        <= 2'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            byte_cnt <= '0;
            rw       <= 1'b0;
            ack_smp  <= 1'b0;
            ack_err  <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            rx_valid <= 1'b0;
            if (state == IDLE) begin
                div_cnt <= '0;
                q       <= 2'd0;
                bit_cnt <= 3'd0;
                if (cmd.start) begin
                    shreg    <= {cmd.addr, cmd.r_w_en};
                    rw       <= cmd.r_w_en;
                    byte_cnt <= cmd.num_bytes;
                    ack_err  <= 1'b0;
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DW'(1);
                if (tick)   q       <= q + 2'd1;
                if (smp_pt) ack_smp <= sda_in;
                if (bit_end && (state == ADDR || state == WRITE || state == READ))
                    bit_cnt <= bit_cnt + 3'd1;
                case (state)
                    ADDR: if (bit_end) shreg <= {shreg[6:0], 1'b0};
                    WRITE: begin
                        if (tx_load)      shreg <= cmd.tx_data;
                        else if (bit_end) shreg <= {shreg[6:0], 1'b0};
                    end
                    READ: begin
                        if (smp_pt) shreg <= {shreg[6:0], sda_in};
                        if (rx_upd) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end
                    end
                    ADDR_ACK: if (bit_end && ack_smp) ack_err <= 1'b1;
                    WRITE_ACK: begin
                        if (bit_end) begin
                            if (ack_smp) ack_err  <= 1'b1;
                            else         byte_cnt <= byte_cnt - CNT_W'(1);
                        end
                    end
                    READ_ACK: if (bit_end) byte_cnt <= byte_cnt - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    assign SDA          = sda_low ? 1'b0 : 1'bz;
    assign SCL          = scl;
    assign state_reg    = state;
    assign cmd.tx_load  = tx_load;
    assign cmd.rx_data  = rx_data;
    assign cmd.rx_valid = rx_valid;
    assign cmd.busy     = (state != IDLE);
    assign cmd.done     = done;
    assign cmd.ack_err  = ack_err;
endmodule

// File: tb/tb_i2c_master_burst.sv
// Directed bench for i2c_master_burst: a transaction table drives a bus-level slave model,
// plus hand-written reset and busy-start sequences.
module tb_i2c_master_burst;
    localparam int CLK_DIV = 4;
    localparam int CNT_W   = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wire        sda;
    logic       scl;
    logic [3:0] state_reg;
    logic       slave_low = 1'b0;

    assign sda = slave_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_master_burst_if #(.CNT_W(CNT_W)) bus_if ();

    i2c_master_burst #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (bus_if.master),
        .SCL       (scl),
        .SDA       (sda),
        .state_reg (state_reg)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [2:0]  nb;
        logic [55:0] data;       // byte j at [55-8j -: 8]: write payload or slave read payload
        int          nack_at;    // 0 none, 1 address, j+2 data byte j
        bit          restart;    // pulse start while busy
        logic [7:0]  exp_addr;
        int          exp_tx;
        int          exp_rx;
        logic        exp_err;
        int          exp_cycles;
        int          exp_bytes;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    // ---------------- bus-level slave and monitor ----------------
    int          cfg_nack_at = 0;
    logic        cfg_rw      = 1'b0;
    logic [2:0]  cfg_nb      = 3'd0;
    logic [55:0] cfg_data    = '0;
    int          rise_cnt    = 0;
    int          stop_cnt    = 0;
    logic        bits[64];
    int          sk, sj, sb;

    always @(negedge sda) if (scl === 1'b1) rise_cnt = 0;
    always @(posedge sda) if (scl === 1'b1) stop_cnt++;

    always @(posedge scl) begin
        if (rise_cnt < 64) bits[rise_cnt] = sda;
        rise_cnt++;
    end

    always @(negedge scl) begin
        sk = rise_cnt;
        slave_low = 1'b0;
        if (sk == 8) begin
            slave_low = (cfg_nack_at != 1);
        end else if (sk >= 9 && cfg_nack_at != 1) begin
            sj = (sk - 9) / 9;
            sb = (sk - 9) % 9;
            if (sj < int'(cfg_nb)) begin
                if (!cfg_rw && sb == 8)    slave_low = (cfg_nack_at != sj + 2);
                else if (cfg_rw && sb < 8) slave_low = !cfg_data[55 - 8*sj - sb];
            end
        end
    end

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (case %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [7:0] bus_byte(input int first);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = bits[first + i];
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic run_vec(input int idx, input vec_t v);
        int   tx_cnt, rx_cnt, busy_cyc;
        bit   done_seen;
        logic [7:0] e;
        cfg_nack_at = v.nack_at;
        cfg_rw      = v.rw;
        cfg_nb      = v.nb;
        cfg_data    = v.data;
        stop_cnt    = 0;
        slave_low   = 1'b0;
        for (int i = 0; i < 64; i++) bits[i] = 1'bx;
        exp_q.delete();
        if (v.rw) for (int j = 0; j < v.exp_bytes; j++) exp_q.push_back(v.data[55-8*j -: 8]);
        tx_cnt = 0; rx_cnt = 0; busy_cyc = 0; done_seen = 0;

        @(negedge clk);
        bus_if.start     = 1'b1;
        bus_if.addr      = v.addr;
        bus_if.r_w_en    = v.rw;
        bus_if.num_bytes = v.nb;
        bus_if.tx_data   = v.data[55 -: 8];
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int c = 0; c < 3000 && !done_seen; c++) begin
            if (c > 0) @(negedge clk);
            if (tx_cnt < 7) bus_if.tx_data = v.data[55-8*tx_cnt -: 8];
            bus_if.start = v.restart && (c == 100);
            bus_if.addr  = (v.restart && c == 100) ? 7'h00 : v.addr;
            if (bus_if.busy)    busy_cyc++;
            if (bus_if.tx_load) tx_cnt++;
            if (bus_if.rx_valid) begin
                rx_cnt++;
                if (exp_q.size() == 0) check("rx_unexpected", idx, 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rx_data", idx, bus_if.rx_data, e);
                end
            end
            if (bus_if.done) done_seen = 1;
        end
        bus_if.start = 1'b0;
        check("done_seen", idx, done_seen, 1);
        check("busy_cycles", idx, busy_cyc, v.exp_cycles);
        check("tx_load_count", idx, tx_cnt, v.exp_tx);
        check("rx_valid_count", idx, rx_cnt, v.exp_rx);
        check("addr_byte", idx, bus_byte(0), v.exp_addr);
        for (int j = 0; j < v.exp_bytes; j++) begin
            if (v.rw) check("master_ack", idx, bits[9+9*j+8], (j == int'(v.nb) - 1) ? 1 : 0);
            else      check("write_byte", idx, bus_byte(9+9*j), v.data[55-8*j -: 8]);
        end
        @(negedge clk);
        check("busy_after_done", idx, bus_if.busy, 0);
        check("done_one_cycle", idx, bus_if.done, 0);
        check("state_idle", idx, state_reg, 0);
        check("ack_err", idx, bus_if.ack_err, v.exp_err);
        check("stop_count", idx, stop_cnt, 1);
        check("exp_q_empty", idx, exp_q.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    // ---------------- test ----------------
    initial begin
        bit seen;
        bus_if.start     = 1'b0;
        bus_if.addr      = 7'h00;
        bus_if.r_w_en    = 1'b0;
        bus_if.num_bytes = '0;
        bus_if.tx_data   = 8'h00;

        //             addr   rw nb  data                nack rs  eaddr  tx rx err cyc   bytes
        vecs[0] = '{7'h47, 0, 2, 56'hB4_3C_00_00_00_00_00, 0, 0, 8'h8E, 2, 0, 0, 464,  2};
        vecs[1] = '{7'h73, 0, 2, 56'h12_34_00_00_00_00_00, 1, 0, 8'hE6, 0, 0, 1, 176,  0};
        vecs[2] = '{7'h73, 1, 3, 56'hC9_55_0F_00_00_00_00, 0, 0, 8'hE7, 0, 3, 0, 608,  3};
        vecs[3] = '{7'h2A, 0, 0, 56'h00_00_00_00_00_00_00, 0, 0, 8'h54, 0, 0, 0, 176,  0};
        vecs[4] = '{7'h19, 0, 3, 56'hA5_5A_FF_00_00_00_00, 3, 0, 8'h32, 2, 0, 1, 464,  2};
        vecs[5] = '{7'h47, 0, 1, 56'h81_00_00_00_00_00_00, 0, 1, 8'h8E, 1, 0, 0, 320,  1};
        vecs[6] = '{7'h01, 1, 7, 56'hA1_B2_C3_D4_E5_F6_07, 0, 0, 8'h03, 0, 7, 0, 1184, 7};

        repeat (4) @(negedge clk);
        check("rst_state", -1, state_reg, 0);
        check("rst_scl", -1, scl, 1);
        check("rst_sda", -1, sda, 1);
        check("rst_busy", -1, bus_if.busy, 0);
        check("rst_done", -1, bus_if.done, 0);
        check("rst_tx_load", -1, bus_if.tx_load, 0);
        check("rst_rx_valid", -1, bus_if.rx_valid, 0);
        check("rst_ack_err", -1, bus_if.ack_err, 0);
        check("rst_rx_data", -1, bus_if.rx_data, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Reset in the middle of the first write byte; a later ping shows recovery.
        cfg_nack_at = 0; cfg_rw = 1'b0; cfg_nb = 3'd2; cfg_data = vecs[0].data;
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.addr = 7'h47; bus_if.r_w_en = 1'b0;
        bus_if.num_bytes = 3'd2; bus_if.tx_data = 8'hB4;
        @(negedge clk);
        bus_if.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (bus_if.tx_load) seen = 1;
        end
        check("mid_tx_load_seen", 100, seen, 1);
        repeat (20) @(negedge clk);
        check("mid_state_write", 100, state_reg, 4);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_state", 100, state_reg, 0);
        check("mid_rst_scl", 100, scl, 1);
        check("mid_rst_sda", 100, sda, 1);
        check("mid_rst_busy", 100, bus_if.busy, 0);
        check("mid_rst_tx_load", 100, bus_if.tx_load, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        run_vec(101, vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_master_burst.md
Name: i2c_master_burst

Overview:
- Parametrised successor to the single-byte I2C_controller: an I2C master that runs multi-byte bursts, with a configurable SCL divider, open-drain SDA, byte-level handshakes and ACK checking.
- Sits between a local register/command interface and the board I2C bus.
- Supports write bursts, read bursts (master ACKs every byte except the last) and address-only pings.

Parameters:
- CLK_DIV, 4: clk cycles per SCL quarter-period. One bit period = 4*CLK_DIV clk cycles. Minimum value 1.
- CNT_W, 3: width of num_bytes. Maximum burst length is 2^CNT_W-1 bytes.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request a transaction; sampled only in IDLE.
- addr  input  7  7-bit slave address, latched on accepted start.
- r_w_en  input  1  1 = read, 0 = write; latched on accepted start.
- num_bytes  input  CNT_W  data bytes in the burst; 0 = address-only ping. Latched on accepted start.
- tx_data  input  8  next write byte; sampled in the cycle tx_load=1.
- tx_load  output  1  one-cycle pulse when tx_data is latched (first clk of each WRITE byte).
- rx_data  output  8  last received byte; held until the next one.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at the end of STOP.
- ack_err  output  1  set on any slave NACK; cleared on the next accepted start.
- SCL  output  1  bus clock; idle high.
- SDA  inout  1  open-drain: drives 0 or z, never drives 1. An external pull-up is required.
- state_reg  output  4  current FSM state, for debug.

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE, SCL=1, SDA released (z), busy=0, done=0, tx_load=0, rx_valid=0, ack_err=0, rx_data=0. Applies mid-transfer too; the bus is released within one cycle.
- Phase counter: every bit is four quarters of CLK_DIV clk each.
  - Q0, Q1: SCL low. SDA changes only at the first clk of Q0.
  - Q2, Q3: SCL high. SDA is sampled on the Q2->Q3 boundary.
- State encoding:
  - IDLE=0, START=1, ADDR=2, ADDR_ACK=3, WRITE=4, WRITE_ACK=5, READ=6, READ_ACK=7, STOP=8.
- IDLE:
  - start=1 latches addr, r_w_en and num_bytes, clears ack_err, moves to START. busy=1 on the next cycle.
  - start is ignored in every other state.
- START (one bit period):
  - SCL=1 throughout Q0-Q3.
  - SDA released in Q0-Q1, driven 0 in Q2-Q3.
  - SCL goes low as ADDR begins.
- ADDR: shifts {addr, r_w_en} MSB first over 8 bit periods.
- ADDR_ACK: SDA released; sample the slave ACK.
  - SDA=1 (NACK): set ack_err, go to STOP.
  - num_bytes=0: go to STOP.
  - Otherwise: go to WRITE if r_w_en=0, READ if r_w_en=1.
- WRITE:
  - tx_load pulses at the first clk of the byte; tx_data is shifted MSB first.
  - Then WRITE_ACK, with SDA released and sampled.
  - NACK: set ack_err, go to STOP immediately, even if bytes remain.
  - ACK with bytes remaining: go to WRITE. Last byte: go to STOP.
- READ:
  - SDA released; 8 bits sampled MSB first.
  - rx_data is updated and rx_valid pulses one clk after the 8th sample.
- READ_ACK:
  - Master drives SDA=0 (ACK) if more bytes remain, releases it (NACK) on the last byte.
  - Then READ or STOP.
- STOP (one bit period):
  - SDA driven 0 in Q0-Q2; SCL low in Q0-Q1, high in Q2-Q3.
  - SDA released at Q3 (the stop condition).
  - done pulses on the final clk of Q3, together with the transition to IDLE. busy falls on the next cycle.
- Byte counter:
  - Decrements after each data-byte ACK phase.
  - Counts exactly num_bytes bytes; it must not wrap.
- Transaction length: (1 + 9 + 9*bytes_transferred + 1) * 4*CLK_DIV clk, where bytes_transferred is cut short by a NACK.

Test Plan:
- Write burst, CLK_DIV=4, addr=0x47, r_w_en=0, num_bytes=2, tx_data 0xB4 then 0x3C, slave ACKs all:
  - SDA bytes on SCL rising edges are 0x8E, 0xB4, 0x3C; tx_load pulses twice.
  - done arrives 464 clk after busy rises; ack_err=0.
- Address NACK: addr=0x73, slave leaves SDA high:
  - ack_err=1, no tx_load or rx_valid, STOP follows directly, done after 176 clk.
- Read burst: addr=0x73, r_w_en=1, num_bytes=3, slave returns 0xC9, 0x55, 0x0F:
  - rx_valid pulses 3 times with those values.
  - Master ACK, ACK, NACK observed; ack_err=0.
- Ping: num_bytes=0, slave ACKs:
  - Only the address byte is sent, then STOP; done after 176 clk, ack_err=0.
- Write NACK mid-burst: num_bytes=3, slave NACKs byte 2:
  - ack_err=1, exactly 2 tx_load pulses, immediate STOP.
- Reset mid-transfer: reset=0 during the WRITE of byte 1:
  - Next clk: state_reg=0, SCL=1, SDA=z, busy=0.
  - A start=1 pulse during busy in another run is ignored.
